// File: rtl/fir_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_pkg                                                                    |
// | Shared types and helpers for the time-multiplexed FIR filter.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fir_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    // Tap 0 = 1, all others 0: the filter comes out of reset as a pass-through.
    localparam int c_reset_coef0 = 1;

    function automatic int acc_w(input int data_w, input int coef_w, input int ntaps);
        return data_w + coef_w + $clog2(ntaps);
    endfunction

    function automatic int reset_coef(input int tap);
        return (tap == 0) ? c_reset_coef0 : 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_mac.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_mac                                                                    |
// | Registered signed multiply-add: acc_out <= acc_in + a*b (clr zeroes it).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fir_mac #(
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int ACC_W = 19
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [ACC_W-1:0] acc_in,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic signed [ACC_W-1:0] acc_out
);

    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0]   w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;

    assign w_prod     = a * b;
    assign w_prod_ext = {{(ACC_W - P_W){w_prod[P_W-1]}}, w_prod};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_out <= '0;
        end else if (clr) begin
            acc_out <= '0;
        end else if (en) begin
            acc_out <= acc_in + w_prod_ext;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_mac_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_mac_param                                                              |
// | NTAPS-tap FIR over one shared MAC; define FIR_SAT_EN for round+saturate.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fir_mac_param
    import fir_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int NTAPS  = 8,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        x_dat,
    input  logic                     x_vld,
    output logic                     x_rdy,
    input  logic                     coef_we,
    input  logic [$clog2(NTAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]        coef_dat,
    output logic [OUT_W-1:0]         y_dat,
    output logic                     y_vld,
    output logic                     busy
);

    localparam int AW    = $clog2(NTAPS);
    localparam int ACC_W = acc_w(DATA_W, COEF_W, NTAPS);
    localparam int XW    = ((ACC_W > SHIFT + OUT_W) ? ACC_W : SHIFT + OUT_W) + 1;

    state_t                  r_state;
    state_t                  w_next;
    logic [AW-1:0]           r_k;
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           w_rd_idx;
    logic [DATA_W-1:0]       r_dline [NTAPS];
    logic [COEF_W-1:0]       r_coef  [NTAPS];
    logic [OUT_W-1:0]        r_y_dat;
    logic                    r_y_vld;
    logic                    w_accept;
    logic                    w_last;
    logic                    w_mac_clr;
    logic                    w_mac_en;
    logic signed [ACC_W-1:0] w_acc;
    logic signed [XW-1:0]    w_acc_x;
    logic [OUT_W-1:0]        w_y_fmt;

    assign x_rdy    = (r_state == S_IDLE);
    assign busy     = ~x_rdy;
    assign w_accept = x_rdy & x_vld;
    assign w_last   = (r_k == AW'(NTAPS - 1));
    assign y_dat    = r_y_dat;
    assign y_vld    = r_y_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_mac_clr = 1'b0;
        w_mac_en  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (x_vld) begin
                    w_next    = S_MAC;
                    w_mac_clr = 1'b1;
                end
            end
            S_MAC: begin
                w_mac_en = 1'b1;
                if (w_last) begin
                    w_next = S_OUT;
                end
            end
            S_OUT:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // wr_ptr holds the newest sample until OUT, so tap k sits k slots behind it.
    always_comb begin
        if (r_wr_ptr >= r_k) begin
            w_rd_idx = r_wr_ptr - r_k;
        end else begin
            w_rd_idx = AW'({1'b0, r_wr_ptr} + (AW + 1)'(NTAPS) - {1'b0, r_k});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_dline[i] <= '0;
                r_coef[i]  <= COEF_W'(reset_coef(i));
            end
            r_wr_ptr <= '0;
            r_k      <= '0;
            r_y_dat  <= '0;
            r_y_vld  <= 1'b0;
        end else begin
            if (x_rdy && coef_we && ({1'b0, coef_addr} < (AW + 1)'(NTAPS))) begin
                r_coef[coef_addr] <= coef_dat;
            end
            if (w_accept) begin
                r_dline[r_wr_ptr] <= x_dat;
            end
            if (r_state == S_MAC) begin
                r_k <= w_last ? '0 : r_k + AW'(1);
            end
            if (r_state == S_OUT) begin
                r_wr_ptr <= (r_wr_ptr == AW'(NTAPS - 1)) ? '0 : r_wr_ptr + AW'(1);
                r_y_dat  <= w_y_fmt;
            end
            r_y_vld <= (r_state == S_OUT);
        end
    end

    fir_mac #(
        .A_W   (DATA_W),
        .B_W   (COEF_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_mac_clr),
        .en      (w_mac_en),
        .acc_in  (w_acc),
        .a       (r_dline[w_rd_idx]),
        .b       (r_coef[r_k]),
        .acc_out (w_acc)
    );

    assign w_acc_x = {{(XW - ACC_W){w_acc[ACC_W-1]}}, w_acc};

`ifdef FIR_SAT_EN
    localparam logic signed [XW-1:0] c_round = (XW'(1) << SHIFT) >> 1;
    localparam logic signed [XW-1:0] c_max   = (XW'(1) << (OUT_W - 1)) - XW'(1);
    localparam logic signed [XW-1:0] c_min   = ~c_max;

    logic signed [XW-1:0] w_round;

    assign w_round = (w_acc_x + c_round) >>> SHIFT;

    always_comb begin
        if (w_round > c_max) begin
            w_y_fmt = c_max[OUT_W-1:0];
        end else if (w_round < c_min) begin
            w_y_fmt = c_min[OUT_W-1:0];
        end else begin
            w_y_fmt = w_round[OUT_W-1:0];
        end
    end
`else
    logic signed [XW-1:0] w_shr;
    logic                 w_unused_hi;

    // Plain truncation: bits above the output window are discarded (wrap).
    assign w_shr       = w_acc_x >>> SHIFT;
    assign w_y_fmt     = w_shr[OUT_W-1:0];
    assign w_unused_hi = ^w_shr[XW-1:OUT_W];
`endif

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fir_mac_param                                                           |
// | Self-checking bench: directed tables, corner sequences, random vs model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fir_mac_param;

    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int NTAPS  = 8;
    localparam int OUT_W  = 16;
    localparam int SHIFT  = 0;
    localparam int AW     = $clog2(NTAPS);
`ifdef FIR_SAT_EN
    localparam longint SETTLE = 32767;
`else
    localparam longint SETTLE = -2040;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] x_dat;
    logic              x_vld;
    logic              x_rdy;
    logic              coef_we;
    logic [AW-1:0]     coef_addr;
    logic [COEF_W-1:0] coef_dat;
    logic [OUT_W-1:0]  y_dat;
    logic              y_vld;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: hist[0] is the newest sample.
    int hist  [NTAPS];
    int mcoef [NTAPS];

    typedef struct {
        int x;
        int y;
    } vec_t;
    vec_t tv [5];

    fir_mac_param #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .NTAPS  (NTAPS),
        .OUT_W  (OUT_W),
        .SHIFT  (SHIFT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .x_dat     (x_dat),
        .x_vld     (x_vld),
        .x_rdy     (x_rdy),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_dat  (coef_dat),
        .y_dat     (y_dat),
        .y_vld     (y_vld),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NTAPS; i++) begin
            hist[i]  = 0;
            mcoef[i] = (i == 0) ? 1 : 0;
        end
    endfunction

    function automatic void model_push(input int x);
        for (int i = NTAPS - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = x;
    endfunction

    function automatic longint model_out();
        longint acc = 0;
        longint v;
        for (int i = 0; i < NTAPS; i++) acc += longint'(mcoef[i]) * longint'(hist[i]);
`ifdef FIR_SAT_EN
        v = (2 * acc + (longint'(1) <<< SHIFT)) >>> (SHIFT + 1);
        if (v > (longint'(1) <<< (OUT_W - 1)) - 1) v = (longint'(1) <<< (OUT_W - 1)) - 1;
        if (v < -(longint'(1) <<< (OUT_W - 1)))    v = -(longint'(1) <<< (OUT_W - 1));
`else
        v = acc >>> SHIFT;
        v = v & ((longint'(1) <<< OUT_W) - 1);
        if (v >= (longint'(1) <<< (OUT_W - 1))) v -= (longint'(1) <<< OUT_W);
`endif
        return v;
    endfunction

    function automatic int rnd_s8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        x_vld   = 1'b0;
        coef_we = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic coef_write(input int a, input int d);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = AW'(a);
        coef_dat  = COEF_W'(d);
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        mcoef[a] = d;
    endtask

    // Send one sample; optionally write a coefficient on the accepting edge
    // (cw) and/or attempt a write while busy (bw), which must be dropped.
    task automatic send(input int x, input bit bw, input int bw_a, input int bw_d,
                        input bit cw, input int cw_a, input int cw_d, output longint y_got);
        int     cyc;
        bit     got;
        longint exp;
        @(negedge clk);
        cyc = 0;
        while (!x_rdy && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("x_rdy_before_send", x_rdy, 1);
        x_dat = DATA_W'(x);
        x_vld = 1'b1;
        if (cw) begin
            coef_we   = 1'b1;
            coef_addr = AW'(cw_a);
            coef_dat  = COEF_W'(cw_d);
        end
        @(posedge clk);
        #1;
        x_vld   = 1'b0;
        coef_we = 1'b0;
        if (cw) mcoef[cw_a] = cw_d;
        model_push(x);
        exp = model_out();
        got = 1'b0;
        for (cyc = 1; cyc <= NTAPS + 4; cyc++) begin
            @(posedge clk);
            #1;
            coef_we = 1'b0;
            if (y_vld) begin
                got = 1'b1;
                break;
            end
            if (bw && cyc == 2) begin
                coef_we   = 1'b1;
                coef_addr = AW'(bw_a);
                coef_dat  = COEF_W'(bw_d);
            end
        end
        check("latency", got ? cyc : -1, NTAPS + 1);
        y_got = longint'($signed(y_dat));
        check("y_dat", y_got, exp);
        check("x_rdy_at_y_vld", x_rdy, 1);
        @(posedge clk);
        #1;
        check("y_vld_one_cycle", y_vld, 0);
        check("y_dat_held", longint'($signed(y_dat)), exp);
    endtask

    task automatic send_plain(input int x, output longint y_got);
        send(x, 1'b0, 0, 0, 1'b0, 0, 0, y_got);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint yg;
        int     acc_c[$];
        longint expq[$];
        int     ny;
        int     last;
        bit     exp_busy;

        tv[0] = '{x: 1, y: 1};
        tv[1] = '{x: 0, y: 2};
        tv[2] = '{x: 0, y: 3};
        tv[3] = '{x: 0, y: 4};
        tv[4] = '{x: 0, y: 0};

        rst = 1'b1; x_vld = 1'b0; x_dat = '0;
        coef_we = 1'b0; coef_addr = '0; coef_dat = '0;
        model_reset();

        // Reset state and pass-through
        do_reset();
        check("rst_x_rdy", x_rdy, 1);
        check("rst_y_vld", y_vld, 0);
        check("rst_y_dat", y_dat, 0);
        check("rst_busy", busy, 0);
        send_plain(5, yg);
        check("passthru_5", yg, 5);

        // Impulse response table
        do_reset();
        for (int i = 0; i < 4; i++) coef_write(i, i + 1);
        for (int i = 0; i < 5; i++) begin
            send_plain(tv[i].x, yg);
            check("impulse_tbl", yg, tv[i].y);
        end

        // Continuous x_vld: accepts spaced NTAPS+2 apart, none lost or doubled
        do_reset();
        ny = 0;
        last = -100;
        @(negedge clk);
        x_dat = DATA_W'(3);
        x_vld = 1'b1;
        for (int c = 0; c < 32; c++) begin
            if (c > 0) @(negedge clk);
            exp_busy = (c - last) <= NTAPS + 1;
            check("stream_busy", busy, exp_busy);
            check("stream_x_rdy", x_rdy, !exp_busy);
            if (!exp_busy) begin
                last = c;
                acc_c.push_back(c);
                model_push(3);
                expq.push_back(model_out());
            end
            @(posedge clk);
            #1;
            if (y_vld) begin
                ny++;
                check("stream_y", longint'($signed(y_dat)), (expq.size() > 0) ? expq.pop_front() : -99999);
            end
        end
        @(negedge clk);
        x_vld = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (y_vld) begin
                ny++;
                check("stream_y", longint'($signed(y_dat)), (expq.size() > 0) ? expq.pop_front() : -99999);
            end
        end
        check("stream_accepts", acc_c.size(), 4);
        for (int i = 1; i < acc_c.size(); i++) check("stream_interval", acc_c[i] - acc_c[i-1], NTAPS + 2);
        check("stream_outputs", ny, 4);

        // Coefficient write while busy is dropped; in IDLE it lands; with accept it lands first
        do_reset();
        send(1, 1'b1, 0, 7, 1'b0, 0, 0, yg);
        check("busy_wr_first", yg, 1);
        send_plain(2, yg);
        check("busy_wr_dropped", yg, 2);
        coef_write(0, 7);
        send_plain(2, yg);
        check("idle_wr_lands", yg, 14);
        send(1, 1'b0, 0, 0, 1'b1, 0, 4, yg);
        check("wr_with_accept", yg, 4);

        // Full-scale settle
        do_reset();
        for (int i = 0; i < NTAPS; i++) coef_write(i, 127);
        for (int i = 0; i < NTAPS + 2; i++) send_plain(127, yg);
        check("full_scale_settle", yg, SETTLE);

        // Reset in the middle of MAC discards the result and clears the delay line
        do_reset();
        for (int i = 0; i < 3; i++) send_plain(50 + i, yg);
        @(negedge clk);
        x_dat = DATA_W'(4);
        x_vld = 1'b1;
        @(posedge clk);
        #1;
        x_vld = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check("midrst_x_rdy", x_rdy, 1);
        check("midrst_y_vld", y_vld, 0);
        check("midrst_y_dat", y_dat, 0);
        ny = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (y_vld) ny++;
        end
        check("midrst_no_y_vld", ny, 0);
        for (int i = 1; i < NTAPS; i++) coef_write(i, 1);
        send_plain(9, yg);
        check("midrst_then_9", yg, 9);

        // Random samples, coefficients and dropped busy writes against the model
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) coef_write(int'($urandom_range(0, NTAPS - 1)), rnd_s8());
            send(rnd_s8(), 1'($urandom_range(0, 1)), int'($urandom_range(0, NTAPS - 1)), rnd_s8(),
                 ($urandom_range(0, 3) == 0), int'($urandom_range(0, NTAPS - 1)), rnd_s8(), yg);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
